up5k_zx_mem_arbiter: RTL and testbench
======================================

Name: up5k_zx_mem_arbiter

Overview:
- Sequences and shares the single-port 16 Kx8 SPRAM byte memory (ROM/RAM store, 14-bit byte address, 1-cycle read latency) between three requesters:
  - the boot loader (copies the ROM image from flash);
  - the video fetcher (screen/attribute bytes, deadline-critical);
  - the Z80 CPU (read/write).
- Sits between the requesters and the byte-wide SPRAM wrapper, and owns boot-time exclusivity.

Parameters:
- ADDR_W, 14, byte address width of the memory.
- CPU_MAX_WAIT, 3, max consecutive cycles the CPU may lose to video before it is forced ahead.
- WAIT_W, 2, width of the CPU starvation counter (must hold CPU_MAX_WAIT).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- ld_req  input  1  loader write request.
- ld_addr  input  ADDR_W  loader byte address.
- ld_wdata  input  8  loader write data.
- ld_done  input  1  level; loader finished, leave boot.
- ld_ack  output  1  loader request accepted this cycle.
- vid_req  input  1  video read request.
- vid_addr  input  ADDR_W  video byte address.
- vid_ack  output  1  video request accepted.
- vid_rvalid  output  1  vid read data valid on rdata.
- cpu_req  input  1  CPU request.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  ADDR_W  CPU byte address.
- cpu_wdata  input  8  CPU write data.
- cpu_ack  output  1  CPU request accepted.
- cpu_rvalid  output  1  CPU read data valid on rdata.
- rdata  output  8  read data, shared by both read requesters.
- mem_addr  output  ADDR_W  to byte-wide SPRAM wrapper.
- mem_wen  output  1  to wrapper.
- mem_wdata  output  8  to wrapper.
- mem_rdata  input  8  from wrapper, valid the cycle after the read access.
- booting  output  1  high while in BOOT.

Behaviour:
- Reset (async, resetn=0):
  - State enters BOOT; booting=1.
  - All acks, rvalids and mem_wen = 0; mem_addr, mem_wdata and rdata = 0.
  - Starvation counter = 0.
- Requester handshake:
  - The requester holds req and its addr/data stable until it sees ack.
  - ack is a 1-cycle pulse in cycle T, the grant cycle.
  - The requester may change or drop req in T+1.
- Pipeline:
  - T: grant is decided combinationally and ack is asserted.
  - T+1: mem_addr, mem_wen and mem_wdata are registered outputs carrying the granted access.
  - T+2: rdata = mem_rdata (registered), with vid_rvalid or cpu_rvalid pulsed for reads.
  - Read latency from ack to rvalid is exactly 2 cycles.
  - Writes produce no rvalid.
  - Throughput is 1 access per cycle.
- At most one ack per cycle. With no grant, mem_wen=0 in T+1 and mem_addr holds its last value.
- BOOT state:
  - Only the loader is granted; vid_req and cpu_req are ignored (no ack).
  - Loader accesses are always writes.
  - Transition to RUN when ld_done=1 and no loader access is in the T+1 stage.
  - If ld_req and ld_done are both high, the request is granted first and the transition happens the cycle after.
- RUN state:
  - The loader is never granted.
  - Priority is video over CPU, except when the CPU is starving.
  - Starvation counter:
    - increments when cpu_req=1 and video is granted;
    - clears on cpu_ack or when cpu_req=0.
  - When counter == CPU_MAX_WAIT and both request, the CPU wins.
  - The counter saturates at CPU_MAX_WAIT and never wraps.
- RUN is sticky. Only reset returns to BOOT; ld_done falling has no effect.
- Reset mid-access: in-flight pipeline stages are discarded, with no rvalid and no write after resetn rises.
- Address wrap: the address is taken modulo 2^ADDR_W and no range check is made.

Optional Feature:
- Macro: UP5K_ZX_ARB_STATS_EN.
- Defined:
  - Adds output cpu_stall_cnt [15:0]: cycles with cpu_req=1 and no cpu_ack, in RUN only.
  - Saturates at 16'hFFFF and clears on reset.
  - Adds output vid_grant_cnt [15:0] with the same rules, counting vid_acks.
- Undefined: the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package up5k_zx_pkg holds:
  - the state encoding (ST_BOOT, ST_RUN);
  - the requester-id encoding (RQ_NONE, RQ_LD, RQ_VID, RQ_CPU), carried down the pipeline to steer rvalid;
  - ZX_MEM_ADDR_W = 14.
- One sub-module: up5k_zx_arb_pick, the combinational priority/starvation grant picker (inputs: state, reqs, counter; output: one-hot grant). The pipeline and counters stay in the top.

Test Plan:
- Boot fill:
  - Loader writes addr 0..3 with 8'hF3, 8'hAF, 8'h11, 8'hFF while vid_req=cpu_req=1.
  - Expect only ld_acks, and mem_wen=1 in T+1 with matching addr/data.
  - Raise ld_done; expect booting=0 one cycle after the last write stage.
- CPU read after boot: cpu_addr=14'h0002 read. Expect cpu_ack at T, mem_addr=2 at T+1, cpu_rvalid with rdata=8'h11 at T+2.
- Contention:
  - vid_req held continuously, cpu_req held with CPU_MAX_WAIT=3.
  - Expect 3 vid_acks then 1 cpu_ack, repeating; vid_rvalid/cpu_rvalid follow 2 cycles after each ack.
- CPU write/readback:
  - Write 8'h5A to 14'h3FFF, then read it back; expect rdata=8'h5A.
  - Address 14'h4000+k aliases to k.
- Reset mid-operation:
  - Assert resetn=0 in the cycle after cpu_ack (read pending).
  - Expect no cpu_rvalid, booting=1, and video/CPU requests ignored after reset.
- With UP5K_ZX_ARB_STATS_EN: run the contention scenario for 40 cycles; expect cpu_stall_cnt=30 and vid_grant_cnt=30.

Source files
------------

// File: rtl/up5k_zx_pkg.sv
// ---------------------------------------------------------------------------
// up5k_zx_pkg
// Shared types and constants for the ZX SPRAM arbiter slice.
//   zx_state_e : arbiter mode (ST_BOOT while the loader fills the store,
//                ST_RUN once video and CPU share it)
//   zx_rq_e    : requester id, travels down the access pipeline so the
//                read-data stage knows which rvalid to raise
//   GNT_*      : bit positions inside the one-hot grant vector
// ---------------------------------------------------------------------------
package up5k_zx_pkg;

    localparam int ZX_MEM_ADDR_W = 14;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } zx_state_e;

    typedef enum logic [1:0] {
        RQ_NONE = 2'd0,
        RQ_LD   = 2'd1,
        RQ_VID  = 2'd2,
        RQ_CPU  = 2'd3
    } zx_rq_e;

    localparam int GNT_LD  = 0;
    localparam int GNT_VID = 1;
    localparam int GNT_CPU = 2;

endpackage

// File: rtl/up5k_zx_arb_pick.sv
// ---------------------------------------------------------------------------
// up5k_zx_arb_pick
// Combinational grant picker. In BOOT only the loader can win. In RUN video
// beats the CPU unless the CPU has already lost CPU_MAX_WAIT cycles in a row.
// Ports:
//   state    : current arbiter mode
//   ld_req   : loader request
//   vid_req  : video request
//   cpu_req  : CPU request
//   wait_cnt : consecutive cycles the CPU has lost to video
//   grant    : one-hot grant, bit positions GNT_LD / GNT_VID / GNT_CPU
// ---------------------------------------------------------------------------
module up5k_zx_arb_pick
    import up5k_zx_pkg::*;
#(
    parameter int CPU_MAX_WAIT = 3,
    parameter int WAIT_W       = 2
) (
    input  zx_state_e         state,
    input  logic              ld_req,
    input  logic              vid_req,
    input  logic              cpu_req,
    input  logic [WAIT_W-1:0] wait_cnt,
    output logic [2:0]        grant
);

    always_comb begin
        grant = '0;
        if (state == ST_BOOT) begin
            grant[GNT_LD] = ld_req;
        end else if (cpu_req && (!vid_req || wait_cnt == WAIT_W'(CPU_MAX_WAIT))) begin
            // CPU wins when video is idle, or when it is starving
            grant[GNT_CPU] = 1'b1;
        end else if (vid_req) begin
            grant[GNT_VID] = 1'b1;
        end
    end

endmodule

// File: rtl/up5k_zx_mem_arbiter.sv
// ---------------------------------------------------------------------------
// up5k_zx_mem_arbiter
// Shares the single-port 16Kx8 SPRAM between boot loader, video fetcher and
// Z80 CPU, and keeps the loader exclusive until boot completes.
//
// Handshake (all requesters): a requester holds req plus addr/data stable
// until it sees ack. ack is a one-cycle pulse in the grant cycle T; req may
// change or drop in T+1. The access appears on mem_* in T+1 and, for reads,
// rdata is valid with the matching rvalid in T+2.
//
// Ports:
//   clk, resetn                  : clock, async active-low reset
//   ld_req/ld_addr/ld_wdata      : loader write request (BOOT only)
//   ld_done                      : level, loader finished -> RUN
//   ld_ack                       : loader grant pulse
//   vid_req/vid_addr             : video read request
//   vid_ack/vid_rvalid           : video grant pulse / read data valid
//   cpu_req/cpu_we/cpu_addr/...  : CPU read/write request
//   cpu_ack/cpu_rvalid           : CPU grant pulse / read data valid
//   rdata                        : shared read data
//   mem_addr/mem_wen/mem_wdata   : registered access to the SPRAM wrapper
//   mem_rdata                    : SPRAM data, valid the cycle after access
//   booting                      : high while in BOOT
// Optional build macro UP5K_ZX_ARB_STATS_EN adds saturating 16-bit counters
//   cpu_stall_cnt (RUN cycles with cpu_req and no cpu_ack) and
//   vid_grant_cnt (RUN cycles with vid_ack).
// ---------------------------------------------------------------------------
module up5k_zx_mem_arbiter
    import up5k_zx_pkg::*;
#(
    parameter int ADDR_W       = ZX_MEM_ADDR_W,
    parameter int CPU_MAX_WAIT = 3,
    parameter int WAIT_W       = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_wdata,
    input  logic              ld_done,
    output logic              ld_ack,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic              vid_rvalid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_rvalid,
    output logic [7:0]        rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              booting
`ifdef UP5K_ZX_ARB_STATS_EN
    ,
    output logic [15:0]       cpu_stall_cnt,
    output logic [15:0]       vid_grant_cnt
`endif
);

    zx_state_e         state;
    zx_state_e         state_nxt;
    logic [2:0]        grant;
    logic [WAIT_W-1:0] wait_cnt;
    zx_rq_e            s1_rq;

    up5k_zx_arb_pick #(
        .CPU_MAX_WAIT (CPU_MAX_WAIT),
        .WAIT_W       (WAIT_W)
    ) u_pick (
        .state    (state),
        .ld_req   (ld_req),
        .vid_req  (vid_req),
        .cpu_req  (cpu_req),
        .wait_cnt (wait_cnt),
        .grant    (grant)
    );

    // ---- FSM: state register ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_BOOT;
        else         state <= state_nxt;
    end

    // ---- FSM: next state ----
    // Leave BOOT only in a cycle with no loader grant, so the final loader
    // write is already on mem_* when RUN begins. RUN is left only by reset.
    always_comb begin
        state_nxt = state;
        if (state == ST_BOOT && ld_done && !grant[GNT_LD]) state_nxt = ST_RUN;
    end

    // ---- FSM: outputs ----
    always_comb begin
        booting = (state == ST_BOOT);
        ld_ack  = grant[GNT_LD];
        vid_ack = grant[GNT_VID];
        cpu_ack = grant[GNT_CPU];
    end

    // ---- Access stage (T+1): registered SPRAM controls ----
    // Without a grant mem_addr/mem_wdata hold and mem_wen drops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_rq     <= RQ_NONE;
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
        end else begin
            s1_rq   <= RQ_NONE;
            mem_wen <= 1'b0;
            if (grant[GNT_LD]) begin
                s1_rq     <= RQ_LD;
                mem_addr  <= ld_addr;
                mem_wdata <= ld_wdata;
                mem_wen   <= 1'b1;
            end else if (grant[GNT_VID]) begin
                s1_rq     <= RQ_VID;
                mem_addr  <= vid_addr;
            end else if (grant[GNT_CPU]) begin
                s1_rq     <= RQ_CPU;
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
                mem_wen   <= cpu_we;
            end
        end
    end

    // ---- Data stage (T+2): steer read-valid to the owner of the read ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vid_rvalid <= 1'b0;
            cpu_rvalid <= 1'b0;
        end else begin
            vid_rvalid <= (s1_rq == RQ_VID);
            cpu_rvalid <= (s1_rq == RQ_CPU) && !mem_wen;
        end
    end

    // The SPRAM output register already holds the byte in T+2; gating it
    // keeps rdata at zero whenever no read is being returned.
    assign rdata = (vid_rvalid || cpu_rvalid) ? mem_rdata : 8'h00;

    // ---- CPU starvation counter (saturating, never wraps) ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= '0;
        end else if (!cpu_req || grant[GNT_CPU]) begin
            wait_cnt <= '0;
        end else if (grant[GNT_VID] && wait_cnt != WAIT_W'(CPU_MAX_WAIT)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

`ifdef UP5K_ZX_ARB_STATS_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cpu_stall_cnt <= '0;
            vid_grant_cnt <= '0;
        end else if (state == ST_RUN) begin
            if (cpu_req && !grant[GNT_CPU] && cpu_stall_cnt != 16'hFFFF)
                cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
            if (grant[GNT_VID] && vid_grant_cnt != 16'hFFFF)
                vid_grant_cnt <= vid_grant_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_up5k_zx_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_up5k_zx_mem_arbiter
// Bench for up5k_zx_mem_arbiter: directed boot/read/contention/write/reset
// scenarios followed by randomized traffic. A rule-level reference model
// predicts grants, the mem_* access one cycle later and read data two cycles
// later, and is compared with the DUT on every falling edge.
// Build with UP5K_ZX_ARB_STATS_EN to include the statistics counters.
// ---------------------------------------------------------------------------
module tb_up5k_zx_mem_arbiter;

    localparam int MAXW = 3;

    // ---- clock / reset ----
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic        ld_req = 0, ld_done = 0, vid_req = 0, cpu_req = 0, cpu_we = 0;
    logic [13:0] ld_addr = 0, vid_addr = 0, cpu_addr = 0;
    logic [7:0]  ld_wdata = 0, cpu_wdata = 0;
    logic        ld_ack, vid_ack, vid_rvalid, cpu_ack, cpu_rvalid, mem_wen, booting;
    logic [7:0]  rdata, mem_wdata, mem_rdata;
    logic [13:0] mem_addr;
`ifdef UP5K_ZX_ARB_STATS_EN
    logic [15:0] cpu_stall_cnt, vid_grant_cnt;
`endif

    up5k_zx_mem_arbiter dut (
        .clk        (clk),
        .resetn     (resetn),
        .ld_req     (ld_req),
        .ld_addr    (ld_addr),
        .ld_wdata   (ld_wdata),
        .ld_done    (ld_done),
        .ld_ack     (ld_ack),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_ack    (vid_ack),
        .vid_rvalid (vid_rvalid),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rvalid (cpu_rvalid),
        .rdata      (rdata),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .booting    (booting)
`ifdef UP5K_ZX_ARB_STATS_EN
        ,
        .cpu_stall_cnt (cpu_stall_cnt),
        .vid_grant_cnt (vid_grant_cnt)
`endif
    );

    // ---- SPRAM environment: registered read, data valid the next cycle ----
    logic [7:0] spram [0:16383] = '{default: 8'h00};
    always @(posedge clk) begin
        if (mem_wen) spram[mem_addr] <= mem_wdata;
        mem_rdata <= spram[mem_addr];
    end

    // ---- scoreboard bookkeeping ----
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---- reference model ----
    typedef struct {
        int          due;
        bit          rv;
        bit          wen;
        bit          vid;
        logic [13:0] addr;
        logic [7:0]  data;
    } ev_t;

    logic [7:0]  ref_mem [0:16383] = '{default: 8'h00};
    ev_t         ev_q[$];
    ev_t         e;
    bit          m_boot = 1'b1;
    int          m_wait = 0;
    int          m_cyc = 0;
    int          m_stall = 0;
    int          m_vgnt = 0;
    logic [13:0] m_last_addr = '0;
    bit          x_wen, x_wchk, x_vrv, x_crv, g_ld, g_vid, g_cpu;
    logic [7:0]  x_wdata, x_rdata;

    initial begin
        forever begin
            @(negedge clk);
            m_cyc++;
            if (!resetn) begin
                ev_q.delete();
                m_boot = 1'b1; m_wait = 0; m_last_addr = '0; m_stall = 0; m_vgnt = 0;
                check("rst_acks",    32'({ld_ack, vid_ack, cpu_ack}), 32'd0);
                check("rst_rvalid",  32'({vid_rvalid, cpu_rvalid}), 32'd0);
                check("rst_mem_wen", 32'(mem_wen), 32'd0);
                check("rst_mem_addr",32'(mem_addr), 32'd0);
                check("rst_wdata",   32'(mem_wdata), 32'd0);
                check("rst_rdata",   32'(rdata), 32'd0);
                check("rst_booting", 32'(booting), 32'd1);
`ifdef UP5K_ZX_ARB_STATS_EN
                check("rst_stall_cnt", 32'(cpu_stall_cnt), 32'd0);
                check("rst_vgnt_cnt",  32'(vid_grant_cnt), 32'd0);
`endif
                continue;
            end
            // accesses and read returns falling due this cycle
            x_wen = 0; x_wchk = 0; x_vrv = 0; x_crv = 0; x_wdata = '0; x_rdata = '0;
            while (ev_q.size() > 0 && ev_q[0].due == m_cyc) begin
                e = ev_q.pop_front();
                if (e.rv) begin
                    if (e.vid) x_vrv = 1; else x_crv = 1;
                    x_rdata = e.data;
                end else begin
                    x_wen = e.wen;
                    m_last_addr = e.addr;
                    if (e.wen) begin x_wchk = 1; x_wdata = e.data; end
                end
            end
            check("mem_wen",    32'(mem_wen), 32'(x_wen));
            check("mem_addr",   32'(mem_addr), 32'(m_last_addr));
            if (x_wchk) check("mem_wdata", 32'(mem_wdata), 32'(x_wdata));
            check("vid_rvalid", 32'(vid_rvalid), 32'(x_vrv));
            check("cpu_rvalid", 32'(cpu_rvalid), 32'(x_crv));
            if (x_vrv || x_crv) check("rdata", 32'(rdata), 32'(x_rdata));
            check("booting",    32'(booting), 32'(m_boot));
`ifdef UP5K_ZX_ARB_STATS_EN
            check("cpu_stall_cnt", 32'(cpu_stall_cnt), 32'(m_stall));
            check("vid_grant_cnt", 32'(vid_grant_cnt), 32'(m_vgnt));
`endif
            // grant rules
            g_ld  = m_boot && ld_req;
            g_cpu = !m_boot && cpu_req && (!vid_req || m_wait >= MAXW);
            g_vid = !m_boot && vid_req && !g_cpu;
            check("ld_ack",  32'(ld_ack),  32'(g_ld));
            check("vid_ack", 32'(vid_ack), 32'(g_vid));
            check("cpu_ack", 32'(cpu_ack), 32'(g_cpu));
            // schedule the access (next cycle) and read return (cycle after)
            if (g_ld) begin
                ev_q.push_back('{m_cyc + 1, 1'b0, 1'b1, 1'b0, ld_addr, ld_wdata});
                ref_mem[ld_addr] = ld_wdata;
            end
            if (g_vid) begin
                ev_q.push_back('{m_cyc + 1, 1'b0, 1'b0, 1'b0, vid_addr, 8'h00});
                ev_q.push_back('{m_cyc + 2, 1'b1, 1'b0, 1'b1, vid_addr, ref_mem[vid_addr]});
            end
            if (g_cpu) begin
                if (cpu_we) begin
                    ev_q.push_back('{m_cyc + 1, 1'b0, 1'b1, 1'b0, cpu_addr, cpu_wdata});
                    ref_mem[cpu_addr] = cpu_wdata;
                end else begin
                    ev_q.push_back('{m_cyc + 1, 1'b0, 1'b0, 1'b0, cpu_addr, 8'h00});
                    ev_q.push_back('{m_cyc + 2, 1'b1, 1'b0, 1'b0, cpu_addr, ref_mem[cpu_addr]});
                end
            end
            if (!m_boot) begin
                if (cpu_req && !g_cpu && m_stall < 65535) m_stall++;
                if (g_vid && m_vgnt < 65535) m_vgnt++;
            end
            if (!cpu_req || g_cpu) m_wait = 0;
            else if (g_vid && m_wait < MAXW) m_wait++;
            if (m_boot && ld_done && !g_ld) m_boot = 1'b0;
        end
    end

    // ---- driver tasks ----
    task automatic cpu_access(input bit we, input logic [13:0] addr, input logic [7:0] wd,
                              output logic [7:0] rd, output int lat, output logic [13:0] a1);
        bit got;
        got = 0; rd = '0; lat = -1; a1 = '0;
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cpu_ack) begin got = 1; break; end
        end
        check("cpu_ack_wait", 32'(got), 32'd1);
        @(posedge clk); #1;
        cpu_req = 0;
        if (got) begin
            @(negedge clk);
            a1 = mem_addr;
            lat = 1;
            if (!we) begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    lat++;
                    if (cpu_rvalid) begin rd = rdata; break; end
                end
            end
        end
    endtask

    function automatic logic [13:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 14'h3FF0 | 14'($urandom_range(0, 15));
        return 14'($urandom_range(0, 15));
    endfunction

    // ---- stimulus ----
    logic [7:0]  boot_img [4] = '{8'hF3, 8'hAF, 8'h11, 8'hFF};
    logic [7:0]  rd;
    int          lat;
    logic [13:0] a1;
    logic [14:0] wide;
    bit          va, ca;

    initial begin
        repeat (3) @(posedge clk);
        #1 resetn = 1;

        // boot fill with video and CPU clamouring
        vid_req = 1; vid_addr = 14'h0010; cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0001;
        for (int i = 0; i < 4; i++) begin
            ld_req = 1; ld_addr = 14'(i); ld_wdata = boot_img[i]; ld_done = (i == 3);
            @(negedge clk);
            check("boot_ld_ack",  32'(ld_ack), 32'd1);
            check("boot_vid_ack", 32'(vid_ack), 32'd0);
            check("boot_cpu_ack", 32'(cpu_ack), 32'd0);
            @(posedge clk); #1;
        end
        ld_req = 0; vid_req = 0; cpu_req = 0;
        @(negedge clk);
        check("boot_last_wen",  32'(mem_wen), 32'd1);
        check("boot_last_addr", 32'(mem_addr), 32'h3);
        check("boot_last_data", 32'(mem_wdata), 32'hFF);
        check("boot_still",     32'(booting), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("boot_left", 32'(booting), 32'd0);
        @(posedge clk); #1 ld_done = 0;
        repeat (2) @(negedge clk);
        check("run_sticky", 32'(booting), 32'd0);

        // CPU read after boot
        cpu_access(0, 14'h0002, 8'h00, rd, lat, a1);
        check("rd2_mem_addr", 32'(a1), 32'h2);
        check("rd2_latency",  32'(lat), 32'd2);
        check("rd2_data",     32'(rd), 32'h11);

        // contention: 3 video grants then 1 CPU grant, repeating
        @(posedge clk); #1;
        vid_req = 1; vid_addr = 14'h0000; cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0001;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("cont_vid_ack", 32'(vid_ack), 32'(k % 4 != 3));
            check("cont_cpu_ack", 32'(cpu_ack), 32'(k % 4 == 3));
        end
        @(posedge clk); #1;
        vid_req = 0; cpu_req = 0;

        // write / readback at the top address and through the alias
        cpu_access(1, 14'h3FFF, 8'h5A, rd, lat, a1);
        check("wr_top_addr", 32'(a1), 32'h3FFF);
        cpu_access(0, 14'h3FFF, 8'h00, rd, lat, a1);
        check("rd_top_data", 32'(rd), 32'h5A);
        wide = 15'h4000 + 15'd5;
        cpu_access(1, wide[13:0], 8'hC3, rd, lat, a1);
        cpu_access(0, 14'h0005, 8'h00, rd, lat, a1);
        check("alias_data", 32'(rd), 32'hC3);
        cpu_access(0, 14'h0000, 8'h00, rd, lat, a1);
        check("boot_byte0", 32'(rd), 32'hF3);

        // reset with a CPU read in flight
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0002;
        @(negedge clk);
        check("rst_pre_ack", 32'(cpu_ack), 32'd1);
        @(posedge clk); #1;
        cpu_req = 0; resetn = 0;
        @(posedge clk); #1;
        resetn = 1; vid_req = 1; vid_addr = 14'h0003; cpu_req = 1; cpu_addr = 14'h0002;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_rst_rvalid",  32'(cpu_rvalid), 32'd0);
            check("post_rst_acks",    32'({vid_ack, cpu_ack}), 32'd0);
            check("post_rst_booting", 32'(booting), 32'd1);
        end
        @(posedge clk); #1 ld_done = 1;

        // randomized traffic in RUN (loader requests must stay ignored)
        va = 0; ca = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            va = vid_ack; ca = cpu_ack;
            @(posedge clk); #1;
            ld_req = 1'($urandom_range(0, 1)); ld_addr = rand_addr();
            ld_wdata = 8'($urandom_range(0, 255)); ld_done = 1'($urandom_range(0, 1));
            if (!vid_req || va) begin
                vid_req = ($urandom_range(0, 99) < 60); vid_addr = rand_addr();
            end
            if (!cpu_req || ca) begin
                cpu_req = ($urandom_range(0, 99) < 50); cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = rand_addr(); cpu_wdata = 8'($urandom_range(0, 255));
            end
        end
        ld_req = 0; vid_req = 0; cpu_req = 0;
        repeat (4) @(posedge clk);

`ifdef UP5K_ZX_ARB_STATS_EN
        // 40 cycles of contention from a fresh reset
        #1 resetn = 0; ld_done = 0;
        @(posedge clk); #1 resetn = 1; ld_done = 1;
        @(posedge clk); #1 vid_req = 1; cpu_req = 1; cpu_we = 0;
        repeat (40) @(posedge clk);
        #1 vid_req = 0; cpu_req = 0;
        @(negedge clk);
        check("stats_stall_40", 32'(cpu_stall_cnt), 32'd30);
        check("stats_vgnt_40",  32'(vid_grant_cnt), 32'd30);
        repeat (4) @(posedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
